i2c_target_regs: RTL and testbench

I2C target (slave) holding a small byte-wide register file. It is the responder end of the bus driven by the Wishbone-controlled I2C master in the verilog-i2c example. It lets the bench close the loop master→bus→target without a behavioural slave model. It decodes START/STOP, matches a 7-bit address, supports pointer-then-data writes and auto-incrementing reads, and exposes a host-side read port and write strobe for scoreboarding.

---
 rtl/i2c_target_pkg.sv | 9 +
 rtl/i2c_bus_cond.sv | 33 +++
 rtl/i2c_target_regs.sv | 131 +++++++++++++
 tb/tb_i2c_target_regs.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: shared state encoding and bus constants for the I2C register target
package i2c_target_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h50;
endpackage

// File: rtl/i2c_bus_cond.sv
// i2c_bus_cond: pin synchronizers plus SCL edge and START/STOP detection
module i2c_bus_cond (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda
);
  logic [1:0] scl_q, sda_q;
  logic scl_p, sda_p;
  // Reset to the idle-bus level so leaving reset never fakes an edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      scl_q <= 2'b11;
      sda_q <= 2'b11;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_q <= {scl_q[0], scl_i};
      sda_q <= {sda_q[0], sda_i};
      scl_p <= scl_q[1];
      sda_p <= sda_q[1];
    end
  assign scl_rise  = scl_q[1] & ~scl_p;
  assign scl_fall  = ~scl_q[1] & scl_p;
  assign start_det = scl_q[1] & scl_p & sda_p & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_p & ~sda_p & sda_q[1];
  assign sda       = sda_q[1];
endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with pointer-addressed byte register file and host read port
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR,
  parameter int NREGS = 16,
  localparam int PW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_o,
  output logic          sda_t,
  output logic          busy,
  output logic          wr_pulse,
  output logic [PW-1:0] wr_index,
  output logic [7:0]    wr_data,
  input  logic [PW-1:0] host_addr,
  output logic [7:0]    host_rdata
);
  logic scl_rise, scl_fall, start_det, stop_det, sda;
  state_t state;
  logic [3:0] cnt;
  logic [7:0] sh, nb, rd;
  logic [PW-1:0] ptr;
  logic [7:0] regs [NREGS];
  i2c_bus_cond u_cond (
    .clk(clk),
    .rst(rst),
    .scl_i(scl_i),
    .sda_i(sda_i),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start_det(start_det),
    .stop_det(stop_det),
    .sda(sda)
  );
  assign sda_o = 1'b0;
  assign nb = {sh[6:0], sda};
  assign rd = regs[ptr];
  // In the ACK states sda_t itself tells the first falling edge (start driving) from the second (done)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      ptr <= '0;
      sda_t <= 1'b1;
      busy <= 1'b0;
      wr_pulse <= 1'b0;
      wr_index <= '0;
      wr_data <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      wr_pulse <= 1'b0;
      if (start_det) begin
        state <= ADDR;
        cnt <= '0;
        busy <= 1'b1;
        sda_t <= 1'b1;
      end else if (stop_det) begin
        state <= IDLE;
        busy <= 1'b0;
        sda_t <= 1'b1;
      end else
        case (state)
          ADDR: if (scl_rise) begin
            sh <= nb;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) state <= (nb[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
          end
          PTR: if (scl_rise) begin
            sh <= nb;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              ptr <= nb[PW-1:0];
              state <= PTR_ACK;
            end
          end
          WDATA: if (scl_rise) begin
            sh <= nb;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              regs[ptr] <= nb;
              wr_pulse <= 1'b1;
              wr_index <= ptr;
              wr_data <= nb;
              ptr <= ptr + PW'(1);
              state <= WDATA_ACK;
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
            if (sda_t) sda_t <= ACK;
            else begin
              cnt <= '0;
              if (state == ADDR_ACK && sh[0]) begin
                sh <= rd;
                sda_t <= rd[7];
                ptr <= ptr + PW'(1);
                state <= RDATA;
              end else begin
                sda_t <= 1'b1;
                state <= (state == ADDR_ACK) ? PTR : WDATA;
              end
            end
          end
          RDATA: begin
            if (scl_rise) cnt <= cnt + 4'd1;
            if (scl_fall) begin
              sda_t <= cnt[3] ? 1'b1 : sh[~cnt[2:0]];
              if (cnt[3]) state <= RDATA_ACK;
            end
          end
          RDATA_ACK: begin
            if (scl_rise && sda == NACK) state <= IGNORE;
            if (scl_fall) begin
              sh <= rd;
              sda_t <= rd[7];
              ptr <= ptr + PW'(1);
              cnt <= '0;
              state <= RDATA;
            end
          end
          default: ;
        endcase
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) host_rdata <= '0;
    else host_rdata <= regs[host_addr];
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed I2C master transactions against the register target
module tb_i2c_target_regs;
  localparam int Q = 100;
  logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
  logic [3:0] host_addr = '0;
  logic sda_o, sda_t, busy, wr_pulse;
  logic [3:0] wr_index;
  logic [7:0] wr_data, host_rdata;
  wire sda_bus = sda_m & (sda_t | sda_o);
  int np = 0, lows = 0, total = 0, passed = 0, fails = 0;
  logic [3:0] wi_q [8];
  logic [7:0] wd_q [8];
  logic a;
  logic [7:0] d;
  int l0;

  always #5 clk = ~clk;

  i2c_target_regs dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_o(sda_o), .sda_t(sda_t),
    .busy(busy), .wr_pulse(wr_pulse), .wr_index(wr_index), .wr_data(wr_data),
    .host_addr(host_addr), .host_rdata(host_rdata)
  );

  always @(negedge clk) begin
    if (wr_pulse) begin
      wi_q[np % 8] <= wr_index;
      wd_q[np % 8] <= wr_data;
      np <= np + 1;
    end
    if (!sda_t) lows <= lows + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_c;
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic stop_c;
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic bit_w(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic bit_r(output logic b);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = sda_bus; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic wbyte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) bit_w(v[i]);
    bit_r(ack);
  endtask

  task automatic rbyte(output logic [7:0] v, input logic ack);
    for (int i = 7; i >= 0; i--) bit_r(v[i]);
    bit_w(ack);
  endtask

  task automatic hread(input logic [3:0] ad, output logic [7:0] v);
    @(negedge clk) host_addr = ad;
    @(negedge clk);
    @(negedge clk) v = host_rdata;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_sda_t", sda_t, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wr_pulse", wr_pulse, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_sda_o", sda_o, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    start_c;
    wbyte(8'hA0, a); chk("w_addr_ack", a, 0);
    chk("w_busy", busy, 1);
    wbyte(8'h03, a); chk("w_ptr_ack", a, 0);
    wbyte(8'hA5, a); chk("w_d0_ack", a, 0);
    wbyte(8'h5A, a); chk("w_d1_ack", a, 0);
    stop_c;
    chk("w_busy_off", busy, 0);
    chk("w_npulse", np, 2);
    chk("w_idx0", wi_q[0], 3); chk("w_dat0", wd_q[0], 8'hA5);
    chk("w_idx1", wi_q[1], 4); chk("w_dat1", wd_q[1], 8'h5A);
    hread(4'd4, d); chk("w_host4", d, 8'h5A);
    hread(4'd3, d); chk("w_host3", d, 8'hA5);

    start_c;
    wbyte(8'hA0, a); wbyte(8'h0E, a);
    wbyte(8'h11, a); chk("wrap_ack0", a, 0);
    wbyte(8'h22, a); wbyte(8'h33, a); chk("wrap_ack2", a, 0);
    stop_c;
    chk("wrap_npulse", np, 5);
    chk("wrap_idx2", wi_q[4], 0); chk("wrap_dat2", wd_q[4], 8'h33);
    hread(4'd14, d); chk("wrap_r14", d, 8'h11);
    hread(4'd15, d); chk("wrap_r15", d, 8'h22);
    hread(4'd0, d); chk("wrap_r0", d, 8'h33);

    start_c;
    wbyte(8'hA0, a); wbyte(8'h0F, a); chk("rd_ptr_ack", a, 0);
    start_c;
    wbyte(8'hA1, a); chk("rd_addr_ack", a, 0);
    rbyte(d, 1'b0); chk("rd_byte0", d, 8'h22);
    rbyte(d, 1'b1); chk("rd_byte1", d, 8'h33);
    chk("rd_released", sda_t, 1);
    stop_c;
    chk("rd_npulse", np, 5);
    chk("rd_busy_off", busy, 0);

    l0 = lows;
    start_c;
    wbyte(8'hA2, a); chk("mm_addr_nack", a, 1);
    wbyte(8'h00, a); chk("mm_data_nack", a, 1);
    stop_c;
    chk("mm_never_low", lows - l0, 0);
    chk("mm_npulse", np, 5);

    start_c;
    wbyte(8'hA0, a); wbyte(8'h05, a);
    bit_w(1'b1); bit_w(1'b0); bit_w(1'b1); bit_w(1'b1);
    stop_c;
    chk("ab_busy", busy, 0);
    chk("ab_sda_t", sda_t, 1);
    chk("ab_npulse", np, 5);
    hread(4'd5, d); chk("ab_r5", d, 8'h00);
    start_c;
    wbyte(8'hA0, a); wbyte(8'h05, a);
    wbyte(8'h77, a); chk("ab_next_ack", a, 0);
    stop_c;
    chk("ab_next_npulse", np, 6);
    chk("ab_next_idx", wi_q[5], 5);
    hread(4'd5, d); chk("ab_next_r5", d, 8'h77);

    start_c;
    wbyte(8'hA0, a); wbyte(8'h00, a);
    start_c;
    wbyte(8'hA1, a); chk("rr_addr_ack", a, 0);
    chk("rr_driving_low", sda_t, 0);
    rst = 1'b1;
    #1;
    chk("rr_sda_t", sda_t, 1);
    chk("rr_busy", busy, 0);
    sda_m = 1'b1; scl_m = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      hread(4'(i), d);
      chk($sformatf("rr_reg%0d", i), d, 0);
    end
    start_c;
    wbyte(8'hA0, a); chk("rr_next_ack", a, 0);
    wbyte(8'h02, a); wbyte(8'h99, a);
    stop_c;
    chk("rr_next_npulse", np, 7);
    chk("rr_next_idx", wi_q[6], 2);
    hread(4'd2, d); chk("rr_next_r2", d, 8'h99);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
